// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder and the capture controller.
// Holds the decoder state encoding, the error cause codes and the command opcodes.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPCODE,
    S_ARG,
    S_CHECK,
    S_HOLD
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam logic [7:0] OP_ARM       = 8'h01;
  localparam logic [7:0] OP_SET_DIV   = 8'h02;
  localparam logic [7:0] OP_SET_TRIG  = 8'h03;
  localparam logic [7:0] OP_SET_DEPTH = 8'h04;
  localparam logic [7:0] OP_RESET     = 8'hFF;

  // Bit offset of argument byte idx inside the 32-bit little-endian argument.
  function automatic logic [4:0] arg_lsb(input logic [1:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout counter: counts idle clocks while enabled, restarts on i_Clear.
// o_Expired marks the clock edge on which the count reaches TIMEOUT_CLKS-1.
module uart_byte_timer #(
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expired
);

  localparam int CW = $clog2(TIMEOUT_CLKS);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      count <= '0;
    end else if (i_Clear || !i_Enable) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // A byte in the same cycle (i_Clear) always beats the timeout.
  assign o_Expired = i_Enable && !i_Clear && (count == CW'(TIMEOUT_CLKS - 2));

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles SYNC/OPCODE/ARG/XOR frames from the UART receiver byte strobe and
// presents validated commands on a valid/ready port, with a one-cycle error strobe.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         ARG_BYTES    = 4,
  parameter int         TIMEOUT_CLKS = 100000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Cmd_Valid,
  input  logic        i_Cmd_Ready,
  output logic [7:0]  o_Cmd_Opcode,
  output logic [31:0] o_Cmd_Arg,
  output logic        o_Err,
  output logic [1:0]  o_Err_Code
);

  localparam logic [1:0] LAST_ARG = 2'(ARG_BYTES - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  opcode_q;
  logic [31:0] arg_q;
  logic [7:0]  csum_q;
  logic [1:0]  arg_idx;

  logic        load_opcode;
  logic        load_arg;
  logic        err_set;
  logic [1:0]  err_code_set;
  logic        timer_enable;
  logic        timer_expired;
  logic        handshake;
  logic        sync_seen;

  assign timer_enable = (state == S_OPCODE) || (state == S_ARG) || (state == S_CHECK);
  assign handshake    = (state == S_HOLD) && i_Cmd_Ready;
  assign sync_seen    = i_Rx_DV && (i_Rx_Byte == SYNC_BYTE);

  uart_byte_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_byte_timer (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (i_Rx_DV),
    .i_Enable (timer_enable),
    .o_Expired(timer_expired)
  );

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    next_state   = state;
    load_opcode  = 1'b0;
    load_arg     = 1'b0;
    err_set      = 1'b0;
    err_code_set = ERR_NONE;

    unique case (state)
      S_IDLE: begin
        if (sync_seen) next_state = S_OPCODE;
      end

      S_OPCODE: begin
        if (i_Rx_DV) begin
          load_opcode = 1'b1;
          next_state  = S_ARG;
        end else if (timer_expired) begin
          err_set      = 1'b1;
          err_code_set = ERR_TIMEOUT;
          next_state   = S_IDLE;
        end
      end

      S_ARG: begin
        if (i_Rx_DV) begin
          load_arg = 1'b1;
          if (arg_idx == LAST_ARG) next_state = S_CHECK;
        end else if (timer_expired) begin
          err_set      = 1'b1;
          err_code_set = ERR_TIMEOUT;
          next_state   = S_IDLE;
        end
      end

      S_CHECK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == csum_q) begin
            next_state = S_HOLD;
          end else begin
            err_set      = 1'b1;
            err_code_set = ERR_CSUM;
            next_state   = S_IDLE;
          end
        end else if (timer_expired) begin
          err_set      = 1'b1;
          err_code_set = ERR_TIMEOUT;
          next_state   = S_IDLE;
        end
      end

      S_HOLD: begin
        // A byte coinciding with the handshake starts the next frame as if idle.
        if (handshake) begin
          next_state = sync_seen ? S_OPCODE : S_IDLE;
        end else if (i_Rx_DV) begin
          err_set      = 1'b1;
          err_code_set = ERR_OVERRUN;
        end
      end

      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      opcode_q   <= '0;
      arg_q      <= '0;
      csum_q     <= '0;
      arg_idx    <= '0;
      o_Err      <= 1'b0;
      o_Err_Code <= ERR_NONE;
    end else begin
      if (load_opcode) begin
        opcode_q <= i_Rx_Byte;
        csum_q   <= i_Rx_Byte;
        arg_q    <= '0;
        arg_idx  <= '0;
      end else if (load_arg) begin
        arg_q[arg_lsb(arg_idx) +: 8] <= i_Rx_Byte;
        csum_q                       <= csum_q ^ i_Rx_Byte;
        arg_idx                      <= arg_idx + 2'd1;
      end

      o_Err <= err_set;
      if (err_set) o_Err_Code <= err_code_set;
    end
  end

  assign o_Cmd_Valid  = (state == S_HOLD);
  assign o_Cmd_Opcode = opcode_q;
  assign o_Cmd_Arg    = arg_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: table of whole frames, hand-written corner sequences and
// random frame traffic, all compared cycle by cycle against a frame-level model.
module tb_uart_cmd_decoder;
  import uart_cmd_pkg::*;

  localparam int         ARG_BYTES = 4;
  localparam int         TIMEOUT   = 50;
  localparam logic [7:0] SYNC      = 8'hA5;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        i_Cmd_Ready;
  logic        o_Cmd_Valid;
  logic [7:0]  o_Cmd_Opcode;
  logic [31:0] o_Cmd_Arg;
  logic        o_Err;
  logic [1:0]  o_Err_Code;

  always #5 i_Clock = ~i_Clock;

  uart_cmd_decoder #(
    .SYNC_BYTE   (SYNC),
    .ARG_BYTES   (ARG_BYTES),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .o_Cmd_Valid (o_Cmd_Valid),
    .i_Cmd_Ready (i_Cmd_Ready),
    .o_Cmd_Opcode(o_Cmd_Opcode),
    .o_Cmd_Arg   (o_Cmd_Arg),
    .o_Err       (o_Err),
    .o_Err_Code  (o_Err_Code)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: collects the bytes of a frame in a queue and
  // judges the whole frame once it is complete.
  bit          m_in_frame;
  logic [7:0]  m_q[$];
  int          m_idle;
  bit          m_have;
  logic [7:0]  m_op;
  logic [31:0] m_arg;
  bit          m_err;
  logic [1:0]  m_code;

  task automatic model_reset();
    m_in_frame = 0;
    m_q.delete();
    m_idle = 0;
    m_have = 0;
    m_op   = '0;
    m_arg  = '0;
    m_err  = 0;
    m_code = ERR_NONE;
  endtask

  task automatic model_start();
    m_in_frame = 1;
    m_q.delete();
    m_idle = 0;
  endtask

  task automatic model_step(input bit dv, input logic [7:0] b, input bit rdy);
    logic [7:0] x;
    m_err = 0;
    if (m_have) begin
      if (rdy) begin
        m_have = 0;
        if (dv && b == SYNC) model_start();
      end else if (dv) begin
        m_err  = 1;
        m_code = ERR_OVERRUN;
      end
    end else if (m_in_frame) begin
      if (dv) begin
        m_q.push_back(b);
        m_idle = 0;
        if (m_q.size() == ARG_BYTES + 2) begin
          x = 8'h00;
          for (int i = 0; i < ARG_BYTES + 1; i++) x = x ^ m_q[i];
          m_in_frame = 0;
          if (x == m_q[ARG_BYTES + 1]) begin
            m_have = 1;
            m_op   = m_q[0];
            m_arg  = '0;
            for (int i = 0; i < ARG_BYTES; i++) m_arg = m_arg | (32'(m_q[i + 1]) << (8 * i));
          end else begin
            m_err  = 1;
            m_code = ERR_CSUM;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT - 1) begin
          m_in_frame = 0;
          m_err      = 1;
          m_code     = ERR_TIMEOUT;
        end
      end
    end else if (dv && b == SYNC) begin
      model_start();
    end
  endtask

  task automatic compare_outputs();
    check("valid", 32'(o_Cmd_Valid), 32'(m_have));
    check("err", 32'(o_Err), 32'(m_err));
    check("err_code", 32'(o_Err_Code), 32'(m_code));
    if (m_have) begin
      check("opcode", 32'(o_Cmd_Opcode), 32'(m_op));
      check("arg", o_Cmd_Arg, m_arg);
    end
  endtask

  // Called #1 after a rising edge; applies inputs for one cycle, then compares.
  task automatic tick(input bit dv, input logic [7:0] b, input bit rdy);
    i_Rx_DV     = dv;
    i_Rx_Byte   = dv ? b : 8'($urandom);
    i_Cmd_Ready = rdy;
    @(posedge i_Clock);
    model_step(dv, b, rdy);
    #1;
    compare_outputs();
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit rdy);
    tick(1'b1, b, rdy);
    repeat (gap) tick(1'b0, 8'h00, rdy);
  endtask

  task automatic rtick(input bit dv, input logic [7:0] b);
    tick(dv, b, 1'($urandom_range(0, 1)));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 32'(o_Cmd_Valid), 32'd0);
    check({name, "_err"}, 32'(o_Err), 32'd0);
    check({name, "_code"}, 32'(o_Err_Code), 32'd0);
    check({name, "_opcode"}, 32'(o_Cmd_Opcode), 32'd0);
    check({name, "_arg"}, o_Cmd_Arg, 32'd0);
  endtask

  typedef struct {
    logic [55:0] frame;      // first byte in the top bits
    bit          ready;
    bit          exp_valid;
    logic [7:0]  exp_op;
    logic [31:0] exp_arg;
    bit          exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{56'hA5_02_10_27_00_00_35, 1'b1, 1'b1, 8'h02, 32'h0000_2710, 1'b0, ERR_NONE};
    vecs[1] = '{56'hA5_01_00_00_00_00_00, 1'b1, 1'b0, 8'h00, 32'h0,         1'b1, ERR_CSUM};
    vecs[2] = '{56'hA5_01_00_00_00_00_01, 1'b1, 1'b1, 8'h01, 32'h0,         1'b0, ERR_CSUM};
    vecs[3] = '{56'hA5_03_C8_00_00_00_CB, 1'b1, 1'b1, 8'h03, 32'h0000_00C8, 1'b0, ERR_CSUM};
    vecs[4] = '{56'hA5_FF_01_02_03_04_00, 1'b1, 1'b0, 8'h00, 32'h0,         1'b1, ERR_CSUM};

    i_Reset     = 1'b1;
    i_Rx_DV     = 1'b0;
    i_Rx_Byte   = 8'h00;
    i_Cmd_Ready = 1'b0;
    model_reset();
    repeat (3) @(posedge i_Clock);
    #1;
    check_all_zero("reset");
    i_Reset = 1'b0;

    // Whole frames from the table, one byte every 16 clocks, ready held high.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 6; i++) send(vecs[v].frame[8 * (6 - i) +: 8], 15, vecs[v].ready);
      tick(1'b1, vecs[v].frame[7:0], vecs[v].ready);
      check($sformatf("tbl%0d_valid", v), 32'(o_Cmd_Valid), 32'(vecs[v].exp_valid));
      check($sformatf("tbl%0d_err", v), 32'(o_Err), 32'(vecs[v].exp_err));
      if (vecs[v].exp_err) check($sformatf("tbl%0d_code", v), 32'(o_Err_Code), 32'(vecs[v].exp_code));
      if (vecs[v].exp_valid) begin
        check($sformatf("tbl%0d_opcode", v), 32'(o_Cmd_Opcode), 32'(vecs[v].exp_op));
        check($sformatf("tbl%0d_arg", v), o_Cmd_Arg, vecs[v].exp_arg);
      end
      tick(1'b0, 8'h00, vecs[v].ready);
      check($sformatf("tbl%0d_valid_drop", v), 32'(o_Cmd_Valid), 32'd0);
      check($sformatf("tbl%0d_err_drop", v), 32'(o_Err), 32'd0);
      repeat (14) tick(1'b0, 8'h00, vecs[v].ready);
    end

    // Timeout: A5 03 AA then silence.
    begin
      int found;
      found = 0;
      send(SYNC, 15, 1'b1);
      send(8'h03, 15, 1'b1);
      tick(1'b1, 8'hAA, 1'b1);
      for (int k = 1; k <= 60; k++) begin
        tick(1'b0, 8'h00, 1'b1);
        if (found == 0 && o_Err) begin
          found = k;
          check("timeout_code", 32'(o_Err_Code), 32'(ERR_TIMEOUT));
        end
      end
      check("timeout_latency", 32'(found), 32'(TIMEOUT - 1));
      tick(1'b1, 8'h03, 1'b1);
      check("post_timeout_err", 32'(o_Err), 32'd0);
      check("post_timeout_valid", 32'(o_Cmd_Valid), 32'd0);
      repeat (5) tick(1'b0, 8'h00, 1'b1);
    end

    // Overrun while the consumer stalls, then handshake.
    send(SYNC, 3, 1'b0);
    send(8'h04, 3, 1'b0);
    send(8'h78, 3, 1'b0);
    send(8'h56, 3, 1'b0);
    send(8'h34, 3, 1'b0);
    send(8'h12, 3, 1'b0);
    tick(1'b1, 8'h0C, 1'b0);
    check("hold_valid", 32'(o_Cmd_Valid), 32'd1);
    tick(1'b1, 8'h55, 1'b0);
    check("overrun_err", 32'(o_Err), 32'd1);
    check("overrun_code", 32'(o_Err_Code), 32'(ERR_OVERRUN));
    check("overrun_valid", 32'(o_Cmd_Valid), 32'd1);
    check("overrun_opcode", 32'(o_Cmd_Opcode), 32'h04);
    check("overrun_arg", o_Cmd_Arg, 32'h1234_5678);
    tick(1'b0, 8'h00, 1'b0);
    check("overrun_err_pulse", 32'(o_Err), 32'd0);
    tick(1'b0, 8'h00, 1'b1);
    check("handshake_drop", 32'(o_Cmd_Valid), 32'd0);
    repeat (3) tick(1'b0, 8'h00, 1'b0);

    // Back-to-back: handshake in the same cycle as the next SYNC strobe.
    send(SYNC, 2, 1'b0);
    send(8'h01, 2, 1'b0);
    repeat (4) send(8'h00, 2, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    check("b2b_first_opcode", 32'(o_Cmd_Opcode), 32'h01);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, SYNC, 1'b1);
    check("b2b_first_taken", 32'(o_Cmd_Valid), 32'd0);
    check("b2b_no_overrun", 32'(o_Err), 32'd0);
    send(8'h02, 2, 1'b0);
    send(8'h10, 2, 1'b0);
    send(8'h27, 2, 1'b0);
    send(8'h00, 2, 1'b0);
    send(8'h00, 2, 1'b0);
    tick(1'b1, 8'h35, 1'b0);
    check("b2b_second_valid", 32'(o_Cmd_Valid), 32'd1);
    check("b2b_second_opcode", 32'(o_Cmd_Opcode), 32'h02);
    check("b2b_second_arg", o_Cmd_Arg, 32'h0000_2710);
    tick(1'b0, 8'h00, 1'b1);
    check("b2b_second_taken", 32'(o_Cmd_Valid), 32'd0);

    // Asynchronous reset in the middle of the argument bytes.
    send(SYNC, 2, 1'b1);
    send(8'h04, 2, 1'b1);
    send(8'h78, 2, 1'b1);
    tick(1'b1, 8'h56, 1'b1);
    check("pre_reset_opcode", 32'(o_Cmd_Opcode), 32'h04);
    i_Rx_DV = 1'b0;
    #2;
    i_Reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge i_Clock);
    #1;
    check_all_zero("held_reset");
    i_Reset = 1'b0;
    model_reset();
    send(SYNC, 4, 1'b1);
    send(8'h04, 4, 1'b1);
    send(8'h78, 4, 1'b1);
    send(8'h56, 4, 1'b1);
    send(8'h34, 4, 1'b1);
    send(8'h12, 4, 1'b1);
    tick(1'b1, 8'h0C, 1'b1);
    check("post_reset_valid", 32'(o_Cmd_Valid), 32'd1);
    check("post_reset_opcode", 32'(o_Cmd_Opcode), 32'h04);
    check("post_reset_arg", o_Cmd_Arg, 32'h1234_5678);
    repeat (3) tick(1'b0, 8'h00, 1'b1);

    // Random frames: good, corrupted and truncated, with random gaps and ready.
    for (int f = 0; f < 60; f++) begin
      logic [7:0] fb[ARG_BYTES + 3];
      logic [7:0] x;
      int         kind;
      int         nbytes;
      kind  = int'($urandom_range(0, 9));
      fb[0] = SYNC;
      x     = 8'h00;
      for (int i = 1; i <= ARG_BYTES + 1; i++) begin
        fb[i] = 8'($urandom);
        x     = x ^ fb[i];
      end
      fb[ARG_BYTES + 2] = (kind <= 2) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x;
      nbytes = (kind == 0) ? int'($urandom_range(1, ARG_BYTES + 2)) : ARG_BYTES + 3;
      if ($urandom_range(0, 3) == 0) rtick(1'b1, 8'($urandom));
      for (int i = 0; i < nbytes; i++) begin
        rtick(1'b1, fb[i]);
        repeat ($urandom_range(0, 4)) rtick(1'b0, 8'h00);
      end
      if (kind == 0) repeat (TIMEOUT + 2) rtick(1'b0, 8'h00);
      else repeat ($urandom_range(1, 6)) rtick(1'b0, 8'h00);
    end
    repeat (4) tick(1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Downstream of the UART receiver. Consumes the receiver's one-cycle byte-valid pulse plus data byte and assembles fixed-length command frames for the logic-analyzer control path. Frame format: SYNC, OPCODE, ARG_BYTES argument bytes (little-endian), then XOR checksum. Each validated command is presented on a valid/ready interface to the capture controller; malformed, late or overrunning frames are reported on a one-cycle error strobe.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
ARG_BYTES, 4, argument bytes per frame; range 1..4. o_Cmd_Arg is always 32 bits; unused upper bytes read 0.
TIMEOUT_CLKS, 100000, maximum clocks allowed between bytes inside a frame; must be >= 2.

Ports:
i_Clock  in  1  system clock; the same clock as the UART receiver.
i_Reset  in  1  asynchronous, active-high reset.
i_Rx_DV  in  1  one-cycle byte strobe from the UART receiver.
i_Rx_Byte  in  8  received byte; valid only when i_Rx_DV=1.
o_Cmd_Valid  out  1  decoded command available.
i_Cmd_Ready  in  1  consumer accepts the command this cycle.
o_Cmd_Opcode  out  8  command opcode.
o_Cmd_Arg  out  32  command argument; the first argument byte is bits [7:0].
o_Err  out  1  one-cycle error strobe.
o_Err_Code  out  2  error cause, held until the next error: 01 checksum, 10 timeout, 11 overrun.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0; state goes to S_IDLE.
  - Asserting reset mid-frame discards the partial frame.
  - No output toggles while i_Reset=1.
- States: S_IDLE, S_OPCODE, S_ARG, S_CHECK, S_HOLD.
- S_IDLE:
  - A byte equal to SYNC_BYTE -> S_OPCODE.
  - Any other byte is silently discarded; no error.
- S_OPCODE:
  - Next byte goes into the opcode register and into the running XOR, which is seeded with the opcode.
  - Byte counter clears; next state is S_ARG.
- S_ARG:
  - Byte k (0-based) is written to arg bits [8k+7:8k] and XORed into the checksum.
  - After byte ARG_BYTES-1 -> S_CHECK.
  - The arg register is cleared when the opcode is captured, so unused bytes read 0.
- S_CHECK:
  - If the byte equals the running XOR -> S_HOLD, with o_Cmd_Valid=1 from the next clock edge. Latency is 1 cycle after the checksum byte's i_Rx_DV.
  - Otherwise: o_Err=1 for one cycle, o_Err_Code=01, next state S_IDLE, o_Cmd_Valid stays 0.
- SYNC_BYTE has no special meaning inside a frame; it is treated as data.
- Inter-byte timeout (S_OPCODE, S_ARG, S_CHECK only):
  - The counter clears on entry and on every i_Rx_DV.
  - When it reaches TIMEOUT_CLKS-1 without a byte: o_Err pulse, o_Err_Code=10, next state S_IDLE.
  - If i_Rx_DV arrives in that same cycle, the byte wins and no timeout is flagged.
  - Counter width is $clog2(TIMEOUT_CLKS).
- S_HOLD:
  - o_Cmd_Valid=1; o_Cmd_Opcode and o_Cmd_Arg are stable until the handshake.
  - On o_Cmd_Valid & i_Cmd_Ready, o_Cmd_Valid drops at the next edge.
  - A byte arriving in S_HOLD without ready in the same cycle is dropped: o_Err pulse, o_Err_Code=11, remain in S_HOLD with the command intact.
  - A byte arriving in the same cycle as the handshake is evaluated as in S_IDLE. This supports back-to-back frames: SYNC -> S_OPCODE, anything else is discarded, and there is no overrun error.
- Simultaneous error sources cannot occur; at most one error per cycle by construction.
- o_Err is registered, so it is high exactly one cycle per event.

Decomposition:
- Package uart_cmd_pkg:
  - state enum typedef;
  - error-code localparams ERR_NONE=2'b00, ERR_CSUM=2'b01, ERR_TIMEOUT=2'b10, ERR_OVERRUN=2'b11;
  - opcode constants consumed by the capture controller: OP_ARM=8'h01, OP_SET_DIV=8'h02, OP_SET_TRIG=8'h03, OP_SET_DEPTH=8'h04, OP_RESET=8'hFF.
- One sub-module: uart_byte_timer. It is the inter-byte timeout counter, with inputs clear/enable and output expired, parameterised by TIMEOUT_CLKS.

Test Plan:
1. Bytes A5 02 10 27 00 00 35, one every 16 clocks, i_Cmd_Ready held 1 -> o_Cmd_Valid high for 1 cycle, 1 cycle after the last DV, with Opcode=02 and Arg=0x00002710; o_Err never asserts.
2. Bytes A5 01 00 00 00 00 00 (wrong checksum) -> o_Err pulse 1 cycle, o_Err_Code=01, no o_Cmd_Valid. A following valid frame A5 01 00 00 00 00 01 then decodes to Opcode=01, Arg=0.
3. TIMEOUT_CLKS=50; send A5 03 AA and then stop -> o_Err exactly 49 clocks after the AA strobe, code 10, state returns to S_IDLE. The next byte 03 is ignored, with no error.
4. Ready held 0 after a valid frame (Opcode 04, Arg 0x12345678); send byte 55 -> o_Err code 11; Valid, Opcode and Arg unchanged. Then raise ready -> Valid drops next cycle.
5. Ready pulsed in the same cycle as an A5 strobe, followed by a full second frame -> both commands are delivered in order; no overrun error.
6. Assert i_Reset during the S_ARG bytes of a frame, then release -> all outputs 0 immediately (asynchronously). A subsequent full frame decodes correctly.
